// File: rtl/afifo_pack_pkg.sv
// afifo_pack_pkg: shared widths and the accumulator insert helper for afifo_rd_packer.
package afifo_pack_pkg;
    localparam int IN_W = 12;
    localparam int OUT_W = 16;
    localparam int ACC_W = 27;
    localparam int CNT_W = 5;

    function automatic logic [ACC_W-1:0] ins_at(input logic [ACC_W-1:0] acc, input logic [IN_W-1:0] word,
                                               input logic [CNT_W-1:0] pos);
        return acc | (ACC_W'(word) << pos);
    endfunction
endpackage

// File: rtl/pack_out_reg.sv
// pack_out_reg: one-entry registered valid/ready output stage.
module pack_out_reg #(
    parameter int W = 16
) (
    input  logic         rclk,
    input  logic         dirclr,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         oready,
    output logic [W-1:0] odata,
    output logic         ovalid,
    output logic         slotfree
);
    assign slotfree = !ovalid || oready;

    always_ff @(posedge rclk or posedge dirclr) begin
        if (dirclr) begin
            odata  <= '0;
            ovalid <= 1'b0;
        end else if (load) begin
            odata  <= din;
            ovalid <= 1'b1;
        end else if (oready) begin
            ovalid <= 1'b0;
        end
    end
endmodule

// File: rtl/afifo_rd_packer.sv
// afifo_rd_packer: pops 12-bit FIFO words and repacks them LSB-first into 16-bit valid/ready words.
// Define AFIFO_PACK_FLUSH_EN to add a flush input that emits the zero-padded partial word.
module afifo_rd_packer
    import afifo_pack_pkg::*;
#(
    parameter int InWidth  = IN_W,
    parameter int OutWidth = OUT_W
) (
    input  logic                rclk,
    input  logic                dirclr,
    input  logic                rempty,
    input  logic [InWidth-1:0]  rd,
    output logic                r,
    output logic [OutWidth-1:0] odata,
    output logic                ovalid,
`ifdef AFIFO_PACK_FLUSH_EN
    input  logic                flush,
`endif
    input  logic                oready
);
    localparam int AccWidth = InWidth + OutWidth - 1;
    localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OutWidth);
    localparam logic [CNT_W-1:0] IN_C  = CNT_W'(InWidth);
    localparam logic [CNT_W-1:0] ROOM  = CNT_W'(AccWidth - InWidth);

    logic [AccWidth-1:0] acc, acc_s;
    logic [CNT_W-1:0]    cnt, cntd;
    logic                drain, part, load, slotfree, flushpend;

    always_comb begin
        drain = slotfree && cnt >= OUT_C;
        part  = flushpend && slotfree && cnt != '0 && cnt < OUT_C;
        acc_s = drain ? acc >> OutWidth : acc;
        cntd  = drain ? cnt - OUT_C : cnt;
        r     = !rempty && !dirclr && !flushpend && cntd <= ROOM;
        load  = drain || part;
    end

    // Bits above cnt are always zero, so a partial word comes out already padded.
    always_ff @(posedge rclk or posedge dirclr) begin
        if (dirclr) begin
            acc <= '0;
            cnt <= '0;
        end else if (part) begin
            acc <= '0;
            cnt <= '0;
        end else if (r) begin
            acc <= ins_at(acc_s, rd, cntd);
            cnt <= cntd + IN_C;
        end else begin
            acc <= acc_s;
            cnt <= cntd;
        end
    end

`ifdef AFIFO_PACK_FLUSH_EN
    always_ff @(posedge rclk or posedge dirclr) begin
        if (dirclr) flushpend <= 1'b0;
        else flushpend <= flush || (flushpend && !(slotfree && cnt == '0));
    end
`else
    assign flushpend = 1'b0;
`endif

    pack_out_reg #(.W(OutWidth)) u_out (
        .rclk    (rclk),
        .dirclr  (dirclr),
        .load    (load),
        .din     (acc[OutWidth-1:0]),
        .oready  (oready),
        .odata   (odata),
        .ovalid  (ovalid),
        .slotfree(slotfree)
    );
endmodule

// File: tb/tb_afifo_rd_packer.sv
// tb_afifo_rd_packer: FIFO model plus output scoreboard for afifo_rd_packer.
module tb_afifo_rd_packer;
    logic        rclk, dirclr, rempty, r, ovalid, oready, flush;
    logic [11:0] rd;
    logic [15:0] odata;

    logic [11:0] fifo_q[$];
    logic [15:0] exp_q[$];
    logic [63:0] mbits;
    int          mn, checks, errors, npop, nout, viol, gap_bad;
    logic        gap, gap_en, stream_en, pop_s, out_s;
    logic [15:0] odata_s;

    afifo_rd_packer dut (
        .rclk  (rclk),
        .dirclr(dirclr),
        .rempty(rempty),
        .rd    (rd),
        .r     (r),
        .odata (odata),
        .ovalid(ovalid),
`ifdef AFIFO_PACK_FLUSH_EN
        .flush (flush),
`endif
        .oready(oready)
    );

    initial begin
        rclk = 0;
        forever #5 rclk = ~rclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge rclk) begin
        pop_s   = r && !rempty;
        out_s   = ovalid && oready;
        odata_s = odata;
        if (stream_en && !rempty && !r) viol++;
        if (gap_en && gap && r) gap_bad++;
    end

    always @(posedge rclk) begin
        #1;
        if (pop_s && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            npop++;
        end
        if (out_s) begin
            nout++;
            if (exp_q.size() == 0) chk("extra_output", {16'h0, odata_s}, 32'hFFFF_FFFF);
            else chk("odata", {16'h0, odata_s}, {16'h0, exp_q.pop_front()});
        end
        #2;
        if (gap_en) gap = !gap;
        else gap = 1'b0;
        rempty = gap || fifo_q.size() == 0;
        rd = fifo_q.size() > 0 ? fifo_q[0] : 12'h0;
    end

    task automatic step(input int n);
        repeat (n) @(posedge rclk);
        #2;
    endtask

    task automatic feed(input logic [11:0] w);
        fifo_q.push_back(w);
        mbits = mbits | (64'(w) << mn);
        mn += 12;
        if (mn >= 16) begin
            exp_q.push_back(mbits[15:0]);
            mbits = mbits >> 16;
            mn -= 16;
        end
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k;
        for (k = 0; k < lim; k++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !ovalid) break;
            step(1);
        end
        chk(tag, k < lim, 1);
    endtask

    initial begin
        int base, outs;
        checks = 0; errors = 0; npop = 0; nout = 0; viol = 0; gap_bad = 0;
        mbits = 0; mn = 0;
        dirclr = 1; oready = 0; flush = 0; gap = 0; gap_en = 0; stream_en = 0;
        rempty = 1; rd = 0; pop_s = 0; out_s = 0; odata_s = 0;
        step(3);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_odata", odata, 0);
        chk("rst_r", r, 0);
        dirclr = 0;
        step(1);

        // basic packing against literal expectations
        oready = 1;
        fifo_q.push_back(12'hABC); fifo_q.push_back(12'hDEF);
        fifo_q.push_back(12'h123); fifo_q.push_back(12'h456);
        exp_q.push_back(16'hFABC); exp_q.push_back(16'h23DE); exp_q.push_back(16'h4561);
        wait_idle("basic_done", 50);
        step(2);
        chk("basic_ovalid", ovalid, 0);
        chk("basic_r", r, 0);
        chk("basic_cnt", dut.cnt, 0);

        // backpressure
        oready = 0;
        base = npop;
        feed(12'hABC); feed(12'hDEF); feed(12'h123); feed(12'h456);
        feed(12'h789); feed(12'h0AB); feed(12'hCDE); feed(12'hF01);
        step(20);
        chk("bp_pops", npop - base, 3);
        chk("bp_r", r, 0);
        chk("bp_ovalid", ovalid, 1);
        chk("bp_odata", odata, 16'hFABC);
        step(5);
        chk("bp_hold", odata, 16'hFABC);
        chk("bp_pops_hold", npop - base, 3);
        oready = 1;
        wait_idle("bp_done", 60);

        // streaming
        outs = nout;
        stream_en = 1;
        for (int i = 0; i < 400; i++) feed(12'(i * 7 + 1));
        wait_idle("stream_done", 700);
        stream_en = 0;
        chk("stream_outs", nout - outs, 300);
        chk("stream_r_viol", viol, 0);

        // empty-cycle gaps
        gap_en = 1;
        fifo_q.push_back(12'hABC); fifo_q.push_back(12'hDEF);
        fifo_q.push_back(12'h123); fifo_q.push_back(12'h456);
        exp_q.push_back(16'hFABC); exp_q.push_back(16'h23DE); exp_q.push_back(16'h4561);
        wait_idle("gap_done", 80);
        gap_en = 0;
        chk("gap_pop_while_empty", gap_bad, 0);

        // reset mid-packet: the first popped word is lost
        step(2);
        base = npop;
        fifo_q.push_back(12'h5A5);
        for (int k = 0; k < 10 && npop == base; k++) step(1);
        chk("rst_mid_pop", npop - base, 1);
        dirclr = 1;
        mbits = 0; mn = 0;
        feed(12'h111);
        #2;
        chk("rst_mid_r", r, 0);
        chk("rst_mid_rempty", rempty, 0);
        chk("rst_mid_ovalid", ovalid, 0);
        chk("rst_mid_odata", odata, 0);
        step(2);
        dirclr = 0;
        feed(12'h222); feed(12'h333); feed(12'h444);
        wait_idle("rst_mid_done", 60);

`ifdef AFIFO_PACK_FLUSH_EN
        base = npop;
        feed(12'hABC); feed(12'hDEF); feed(12'h123);
        for (int k = 0; k < 20 && npop - base < 3; k++) step(1);
        flush = 1;
        exp_q.push_back(mbits[15:0]);
        mbits = 0; mn = 0;
        step(1);
        flush = 0;
        wait_idle("flush_done", 40);
        step(2);
        chk("flush_pend_clear", dut.flushpend, 0);
        chk("flush_cnt", dut.cnt, 0);
`endif

        step(2);
        chk("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
